// File: rtl/bg_tile_pipeline.sv
// Background fetch-and-shift pipeline: fetches NT/attribute/pattern bytes in
// 8-cycle tile groups and emits one 4-bit palette index per visible dot.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for line_start; busy drops the cycle after line_done
// PREFETCH | 16 cycles fetching tiles 0 and 1 into the shifters
// VISIBLE  | 8*TILES cycles shifting out pixels while fetching tiles 2..TILES+1
// DONE     | one cycle; raises line_done for the following cycle
module bg_tile_pipeline #(
  parameter int TILES    = 32,
  parameter int PREFETCH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [4:0]  coarse_x0,
  input  logic [4:0]  coarse_y,
  input  logic [2:0]  fine_y,
  input  logic [2:0]  fine_x,
  input  logic [1:0]  nt_sel,
  input  logic        pt_sel,
  input  logic        bg_enable,
  input  logic        show_left,
  output logic [13:0] vram_addr,
  input  logic [7:0]  vram_data,
  output logic [3:0]  pixel,
  output logic        pixel_valid,
  output logic        line_done,
  output logic        busy
);
  localparam int PIX     = 8 * TILES;
  localparam int PRE_CYC = 8 * PREFETCH;
  localparam int TW      = (PIX > PRE_CYC) ? $clog2(PIX) : $clog2(PRE_CYC);

  typedef enum logic [1:0] {S_IDLE, S_PREFETCH, S_VISIBLE, S_DONE} state_t;

  state_t        state;
  logic [2:0]    phase;
  logic [TW-1:0] timer;
  logic [4:0]    cx, cy;
  logic [2:0]    fy, fx;
  logic [1:0]    nt;
  logic          pt, en, left_en;
  logic [7:0]    nt_byte, plo_byte;
  logic [1:0]    attr_bits;
  logic [15:0]   sh_plo, sh_phi, sh_alo, sh_ahi;

  logic [4:0] cx_inc;
  logic [1:0] nt_inc;
  logic [2:0] attr_idx;
  logic [3:0] bsel;
  logic [3:0] px_raw;
  logic       left_zone;

  assign cx_inc    = cx + 5'd1;
  assign nt_inc    = (cx == 5'd31) ? {nt[1], ~nt[0]} : nt;
  assign attr_idx  = {cy[1], cx[1], 1'b0};
  assign bsel      = 4'd15 - {1'b0, fx};
  assign px_raw    = {sh_ahi[bsel], sh_alo[bsel], sh_phi[bsel], sh_plo[bsel]};
  // timer counts down through VISIBLE, so the first 8 dots are the top 8 values
  assign left_zone = (timer >= TW'(PIX - 8));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      phase       <= '0;
      timer       <= '0;
      cx          <= '0;
      cy          <= '0;
      fy          <= '0;
      fx          <= '0;
      nt          <= '0;
      pt          <= 1'b0;
      en          <= 1'b0;
      left_en     <= 1'b0;
      nt_byte     <= '0;
      plo_byte    <= '0;
      attr_bits   <= '0;
      sh_plo      <= '0;
      sh_phi      <= '0;
      sh_alo      <= '0;
      sh_ahi      <= '0;
      vram_addr   <= '0;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      line_done   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      line_done   <= 1'b0;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (line_done) busy <= 1'b0;
          if (line_start && !busy) begin
            state     <= S_PREFETCH;
            busy      <= 1'b1;
            phase     <= '0;
            timer     <= TW'(PRE_CYC - 1);
            cx        <= coarse_x0;
            cy        <= coarse_y;
            fy        <= fine_y;
            fx        <= fine_x;
            nt        <= nt_sel;
            pt        <= pt_sel;
            en        <= bg_enable;
            left_en   <= show_left;
            vram_addr <= {2'b10, nt_sel, coarse_y, coarse_x0};
          end
        end
        S_PREFETCH, S_VISIBLE: begin
          phase <= phase + 3'd1;
          // each odd phase captures the byte for the address of the previous
          // even phase and presents the address for the next even phase
          case (phase)
            3'd1: begin
              nt_byte   <= vram_data;
              vram_addr <= {2'b10, nt, 4'b1111, cy[4:2], cx[4:2]};
            end
            3'd3: begin
              attr_bits <= vram_data[attr_idx +: 2];
              vram_addr <= {1'b0, pt, nt_byte, 1'b0, fy};
            end
            3'd5: begin
              plo_byte  <= vram_data;
              vram_addr <= {1'b0, pt, nt_byte, 1'b1, fy};
            end
            3'd7: begin
              cx        <= cx_inc;
              nt        <= nt_inc;
              vram_addr <= {2'b10, nt_inc, cy, cx_inc};
            end
            default: ;
          endcase

          if (phase == 3'd7) begin
            if (state == S_PREFETCH) begin
              sh_plo <= {sh_plo[7:0], plo_byte};
              sh_phi <= {sh_phi[7:0], vram_data};
              sh_alo <= {sh_alo[7:0], {8{attr_bits[0]}}};
              sh_ahi <= {sh_ahi[7:0], {8{attr_bits[1]}}};
            end else begin
              sh_plo <= {sh_plo[14:7], plo_byte};
              sh_phi <= {sh_phi[14:7], vram_data};
              sh_alo <= {sh_alo[14:7], {8{attr_bits[0]}}};
              sh_ahi <= {sh_ahi[14:7], {8{attr_bits[1]}}};
            end
          end else if (state == S_VISIBLE) begin
            sh_plo <= {sh_plo[14:0], 1'b0};
            sh_phi <= {sh_phi[14:0], 1'b0};
            sh_alo <= {sh_alo[14:0], 1'b0};
            sh_ahi <= {sh_ahi[14:0], 1'b0};
          end

          if (state == S_VISIBLE) begin
            pixel_valid <= 1'b1;
            if (en && (|px_raw[1:0]) && !(!left_en && left_zone)) pixel <= px_raw;
          end

          if (timer == '0) begin
            if (state == S_PREFETCH) begin
              state <= S_VISIBLE;
              timer <= TW'(PIX - 1);
            end else begin
              state <= S_DONE;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_DONE: begin
          line_done <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bg_tile_pipeline.sv
// Bench for bg_tile_pipeline: VRAM image plus a per-line reference model built
// from tile arithmetic; a negedge monitor compares every cycle of each line.
module tb_bg_tile_pipeline;
  localparam int TILES = 32;
  localparam int PIX   = 8 * TILES;

  logic        clk = 1'b0;
  logic        reset, line_start;
  logic [4:0]  coarse_x0, coarse_y;
  logic [2:0]  fine_y, fine_x;
  logic [1:0]  nt_sel;
  logic        pt_sel, bg_enable, show_left;
  logic [13:0] vram_addr;
  logic [7:0]  vram_data;
  logic [3:0]  pixel;
  logic        pixel_valid, line_done, busy;

  bg_tile_pipeline #(.TILES(TILES), .PREFETCH(2)) dut (
    .clk(clk), .reset(reset), .line_start(line_start),
    .coarse_x0(coarse_x0), .coarse_y(coarse_y), .fine_y(fine_y), .fine_x(fine_x),
    .nt_sel(nt_sel), .pt_sel(pt_sel), .bg_enable(bg_enable), .show_left(show_left),
    .vram_addr(vram_addr), .vram_data(vram_data), .pixel(pixel),
    .pixel_valid(pixel_valid), .line_done(line_done), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:16383];
  always @(posedge clk) vram_data <= mem[vram_addr];

  int checks = 0, errors = 0;
  int cyc_cnt = 0, t0 = 0;
  bit mon_en = 1'b0;
  int cfg_cx0, cfg_cy, cfg_fy, cfg_fx, cfg_nt, cfg_pt, cfg_en, cfg_left;
  int t_addr [0:TILES+1][0:3];
  int tpix [0:8*(TILES+2)-1];
  int exp_pix [0:PIX-1];
  int cap [0:PIX-1];
  int nt_log [0:TILES+1];
  int valid_cnt, done_rel, rel_m, g_m, ph_m;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic init_mem(input int attr);
    for (int a = 0; a < 16384; a++) mem[a] = 8'h00;
    for (int r = 0; r < 8; r++) begin
      mem['h0010 + r] = 8'hF0; mem['h0018 + r] = 8'h0F;
      mem['h0020 + r] = 8'hAA; mem['h0028 + r] = 8'hCC;
      mem['h1010 + r] = 8'h3C; mem['h1018 + r] = 8'hFF;
      mem['h1020 + r] = 8'h81; mem['h1028 + r] = 8'h18;
    end
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < 960; k++) mem['h2000 + n*'h400 + k] = (n == 1) ? 8'h02 : 8'h01;
      for (int k = 0; k < 64; k++) mem['h2000 + n*'h400 + 960 + k] = 8'(attr);
    end
  endtask

  task automatic set_cfg(input int cx0, input int cy, input int fy, input int fx,
                         input int nt, input int pt, input int en, input int left);
    cfg_cx0 = cx0; cfg_cy = cy; cfg_fy = fy; cfg_fx = fx;
    cfg_nt = nt; cfg_pt = pt; cfg_en = en; cfg_left = left;
    coarse_x0 = 5'(cx0); coarse_y = 5'(cy); fine_y = 3'(fy); fine_x = 3'(fx);
    nt_sel = 2'(nt); pt_sel = 1'(pt); bg_enable = 1'(en); show_left = 1'(left);
  endtask

  // Reference: per-tile addresses and pixels from scroll arithmetic.
  task automatic build_model();
    int c, cxv, n, nta, ata, ntb, pla, quad, pal, lo, hi, v;
    for (int t = 0; t < TILES + 2; t++) begin
      c   = cfg_cx0 + t;
      cxv = c % 32;
      n   = cfg_nt ^ ((c / 32) % 2);
      nta = 'h2000 + n*'h400 + cfg_cy*32 + cxv;
      ata = 'h2000 + n*'h400 + 'h3C0 + (cfg_cy / 4)*8 + cxv / 4;
      ntb = int'(mem[nta]);
      pla = cfg_pt*'h1000 + ntb*16 + cfg_fy;
      quad = ((cfg_cy / 2) % 2)*2 + (cxv / 2) % 2;
      pal = (int'(mem[ata]) >> (2*quad)) & 3;
      t_addr[t][0] = nta; t_addr[t][1] = ata;
      t_addr[t][2] = pla; t_addr[t][3] = pla + 8;
      for (int p = 0; p < 8; p++) begin
        lo = (int'(mem[pla]) >> (7 - p)) & 1;
        hi = (int'(mem[pla + 8]) >> (7 - p)) & 1;
        tpix[t*8 + p] = pal*4 + hi*2 + lo;
      end
    end
    for (int i = 0; i < PIX; i++) begin
      v = tpix[i + cfg_fx];
      if (cfg_en == 0 || (v % 4) == 0 || (cfg_left == 0 && i < 8)) v = 0;
      exp_pix[i] = v;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      rel_m = cyc_cnt - t0;
      chk("busy", int'(busy), (rel_m >= 1 && rel_m <= 18 + PIX) ? 1 : 0);
      chk("pixel_valid", int'(pixel_valid), (rel_m >= 18 && rel_m <= 17 + PIX) ? 1 : 0);
      chk("line_done", int'(line_done), (rel_m == 18 + PIX) ? 1 : 0);
      if (pixel_valid) valid_cnt++;
      if (line_done) done_rel = rel_m;
      if (rel_m >= 18 && rel_m <= 17 + PIX) begin
        cap[rel_m - 18] = int'(pixel);
        chk("pixel", int'(pixel), exp_pix[rel_m - 18]);
      end
      if (rel_m >= 1 && rel_m <= 16 + PIX) begin
        g_m = (rel_m - 1) / 8;
        ph_m = (rel_m - 1) % 8;
        chk("vram_addr", int'(vram_addr), t_addr[g_m][ph_m / 2]);
        if (ph_m == 0) nt_log[g_m] = int'(vram_addr);
      end
    end
  end

  // collide != 0 also pulses line_start (with scrambled inputs) on that cycle
  // and on the line_done cycle; both must be ignored.
  task automatic run_line(input int collide);
    build_model();
    valid_cnt = 0; done_rel = -1;
    @(posedge clk); #1;
    line_start = 1'b1; t0 = cyc_cnt; mon_en = 1'b1;
    while (cyc_cnt - t0 < 21 + PIX) begin
      @(posedge clk); #1;
      line_start = (collide != 0 && ((cyc_cnt - t0) == collide || (cyc_cnt - t0) == 18 + PIX));
      if (line_start) begin
        coarse_x0 = ~coarse_x0; fine_x = ~fine_x; bg_enable = ~bg_enable;
      end
    end
    mon_en = 1'b0; line_start = 1'b0;
  endtask

  task automatic check_lits(input string name, input int base, input int v0, input int v1,
                            input int v2, input int v3, input int v4, input int v5,
                            input int v6, input int v7);
    int lit [8];
    lit = '{v0, v1, v2, v3, v4, v5, v6, v7};
    for (int i = 0; i < 8; i++) chk(name, cap[base + i], lit[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; line_start = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 1, 1);
    init_mem(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vram_addr", int'(vram_addr), 0);
    chk("rst_pixel", int'(pixel), 0);
    chk("rst_pixel_valid", int'(pixel_valid), 0);
    chk("rst_line_done", int'(line_done), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clk); #1; reset = 1'b0;

    set_cfg(0, 0, 0, 0, 0, 0, 1, 1); run_line(0);
    check_lits("pattern_px", 0, 1, 1, 1, 1, 2, 2, 2, 2);
    chk("pattern_valid_cnt", valid_cnt, 256);
    chk("pattern_done_cycle", done_rel, 274);

    set_cfg(0, 0, 0, 3, 0, 0, 1, 1); run_line(0);
    check_lits("finex_px", 0, 1, 2, 2, 2, 2, 1, 1, 1);

    set_cfg(30, 0, 5, 0, 0, 0, 1, 1); run_line(0);
    chk("wrap_nt0", nt_log[0], 'h201E);
    chk("wrap_nt2", nt_log[2], 'h2400);
    chk("wrap_nt3", nt_log[3], 'h2401);
    chk("wrap_tile2_px0", cap[16], 3);

    init_mem('hE4);
    set_cfg(2, 2, 0, 0, 0, 0, 1, 1); run_line(0);
    chk("attr_t0_lo", cap[0], 13);
    chk("attr_t0_hi", cap[4], 14);
    chk("attr_t1_lo", cap[8], 13);
    chk("attr_t2_lo", cap[16], 9);
    chk("attr_t2_hi", cap[20], 10);

    init_mem(0);
    set_cfg(0, 0, 0, 0, 0, 0, 1, 0); run_line(0);
    check_lits("left_mask_px", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("left_mask_px8", cap[8], 1);

    set_cfg(0, 0, 0, 0, 0, 0, 0, 1); run_line(0);
    chk("bg_off_valid_cnt", valid_cnt, 256);
    chk("bg_off_px100", cap[100], 0);
    chk("bg_off_done_cycle", done_rel, 274);

    set_cfg(5, 7, 2, 1, 3, 1, 1, 1); run_line(50);
    chk("collide_valid_cnt", valid_cnt, 256);
    chk("collide_done_cycle", done_rel, 274);

    set_cfg(0, 0, 0, 0, 0, 0, 1, 1);
    build_model();
    valid_cnt = 0; done_rel = -1;
    @(posedge clk); #1;
    line_start = 1'b1; t0 = cyc_cnt; mon_en = 1'b1;
    while (cyc_cnt - t0 < 100) begin
      @(posedge clk); #1; line_start = 1'b0;
    end
    reset = 1'b1; mon_en = 1'b0;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("midrst_pixel", int'(pixel), 0);
    chk("midrst_pixel_valid", int'(pixel_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_line_done", int'(line_done), 0);
    chk("midrst_vram_addr", int'(vram_addr), 0);
    n = 0;
    repeat (400) begin
      @(negedge clk);
      if (line_done || busy) n++;
    end
    chk("midrst_no_activity", n, 0);

    run_line(0);
    chk("post_rst_done_cycle", done_rel, 274);
    check_lits("post_rst_px", 0, 1, 1, 1, 1, 2, 2, 2, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
